// File: rtl/sevseg_reader.sv
// Loopback reader for active-low seven-segment buses: decodes each digit back to a
// nibble and commits a reading once the pattern has held steady, on a valid/ready port.
module sevseg_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [7*DIGITS-1:0]   seg_in,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int             CW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX    = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_COMMIT = CW'(STABLE_CYCLES - 1);

    logic [7*DIGITS-1:0] sample_q, sample_d;
    logic [7*DIGITS-1:0] committed_q, committed_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    logic [4*DIGITS-1:0] decValue;
    logic [DIGITS-1:0]   decBlank;
    logic [DIGITS-1:0]   decErr;
    logic                segEqual;
    logic                commitNow;

    // Returns {err, blank, nibble} for one active-low gfedcba pattern.
    function automatic logic [5:0] decodeGlyph(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            7'h40:   res = 6'h00;
            7'h79:   res = 6'h01;
            7'h24:   res = 6'h02;
            7'h30:   res = 6'h03;
            7'h19:   res = 6'h04;
            7'h12:   res = 6'h05;
            7'h02:   res = 6'h06;
            7'h78:   res = 6'h07;
            7'h00:   res = 6'h08;
            7'h10:   res = 6'h09;
            7'h08:   res = 6'h0A;
            7'h03:   res = 6'h0B;
            7'h46:   res = 6'h0C;
            7'h21:   res = 6'h0D;
            7'h06:   res = 6'h0E;
            7'h0E:   res = 6'h0F;
            7'h7F:   res = 6'b01_0000;
            default: res = 6'b10_0000;
        endcase
        return res;
    endfunction

    always_comb begin
        logic [5:0] dec;
        decValue = '0;
        decBlank = '0;
        decErr   = '0;
        for (int d = 0; d < DIGITS; d++) begin
            dec                = decodeGlyph(seg_in[7*d +: 7]);
            decValue[4*d +: 4] = dec[3:0];
            decBlank[d]        = dec[4];
            decErr[d]          = dec[5];
        end
    end

    assign segEqual  = (seg_in == sample_q);
    // The counter saturates, so the commit compare is true once per stable run.
    assign commitNow = en && segEqual && (cnt_q == CNT_COMMIT) && (seg_in != committed_q);

    always_comb begin
        sample_d    = sample_q;
        committed_d = committed_q;
        cnt_d       = cnt_q;
        value_d     = value_q;
        blank_d     = blank_q;
        err_d       = err_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;

        if (en) begin
            sample_d = seg_in;
            if (segEqual) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
            end
        end

        if (commitNow) begin
            committed_d = seg_in;
            value_d     = decValue;
            blank_d     = decBlank;
            err_d       = decErr;
            valid_d     = 1'b1;
            if (valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sample_q    <= '1;
            committed_q <= '1;
            cnt_q       <= '0;
            value_q     <= '0;
            blank_q     <= '1;
            err_q       <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sample_q    <= sample_d;
            committed_q <= committed_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            blank_q     <= blank_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign value     = value_q;
    assign blank     = blank_q;
    assign err       = err_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/sevseg_reader.md
# sevseg_reader

Reads back the active-low seven-segment buses driven by the display decoders and recovers the hex digits they show. Each bus is decoded back to a nibble, with separate flags for blank and illegal patterns. A new reading is committed only after the segment pattern has held steady for a set number of cycles. Each committed reading is presented on a valid/ready handshake. The block sits beside the display path as a loopback checker for the watch/counter logic on the 50 MHz domain.

## Interface
- `DIGITS`, 4: number of seven-segment buses read.
- `STABLE_CYCLES`, 4: number of consecutive equal compares required before a commit; legal values are ≥1.
- `clk`  in  1: system clock (CLOCK_50 domain).
- `reset`  in  1: synchronous, active-low reset.
- `en`  in  1: sample enable; when low, the sample register and stability counter hold.
- `seg_in`  in  7*DIGITS: segment buses, active-low, gfedcba; digit d occupies bits [7d+6:7d].
- `value`  out  4*DIGITS: decoded nibbles; digit d occupies bits [4d+3:4d].
- `blank`  out  DIGITS: digit pattern was 7'b1111111.
- `err`  out  DIGITS: digit pattern was neither a legal hex glyph nor blank.
- `out_valid`  out  1: committed reading is pending.
- `out_ready`  in  1: consumer accepts the reading.
- `overrun`  out  1: sticky; a pending reading was overwritten before it was accepted.

## Operation
- Glyph set (active-low), mapping 0-F in order: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Per-digit decode:
  - Legal glyph: nibble = digit value, blank=0, err=0.
  - 7'h7F: nibble=0, blank=1, err=0.
  - Any other pattern: nibble=0, blank=0, err=1.
- `sample` register: on every enabled edge, `sample <= seg_in`.
- Stability counter `cnt`:
  - Width is clog2(STABLE_CYCLES+1).
  - On an enabled edge where seg_in==sample: `cnt <= min(cnt+1, STABLE_CYCLES)`.
  - On an enabled edge where seg_in!=sample: `cnt <= 0`.
- Commit condition: enabled edge, seg_in==sample, cnt==STABLE_CYCLES-1, and seg_in != `committed`.
  - On commit: `committed <= seg_in`; value/blank/err load the decode of seg_in; out_valid <= 1.
  - Saturation means each stable pattern commits at most once.
  - A glitch that returns to the committed pattern produces no commit.
- Handshake:
  - out_valid && out_ready at an edge with no commit: out_valid <= 0.
  - Commit and accept on the same edge: the new data loads, out_valid stays 1, overrun is unchanged.
  - Commit while out_valid=1 and out_ready=0: the data is overwritten, out_valid stays 1, overrun <= 1.
  - value/blank/err hold while out_valid=1 unless a commit occurs.
- `en` gates only `sample` and `cnt`. The handshake, accept and the overrun logic run every cycle.
- Reset values:
  - value=0, blank all 1s, err=0, out_valid=0, overrun=0.
  - sample and committed = all 1s; cnt=0.
  - Consequence: an all-blank display after reset never commits.
- overrun clears only on reset.

## Timing
- All state updates on posedge clk; reset is sampled only at the edge. A reset low between edges has no effect.
- Pattern P first present at edge 0 (so sample=P after edge 0) and held with en=1: equal compares occur at edges 1..STABLE_CYCLES. The commit is at edge STABLE_CYCLES, with out_valid visible after it.
- Latency: STABLE_CYCLES+1 edges from pattern arrival to out_valid. With the default, that is 5 edges.
- Outputs are registered; there is no combinational path from seg_in or out_ready to any output.
- Reset mid-stability or mid-handshake: all state returns to its reset value at that edge, and the pending reading is lost.
- STABLE_CYCLES=1: commit on the first edge where seg_in equals the previous sample.

## Test plan
- Reset: hold reset=0 for 2 edges with arbitrary seg_in -> value=0, blank=4'b1111, err=0, out_valid=0, overrun=0.
- Basic read:
  - Stimulus: seg_in digit0=0100100, digit1=1111001, digits 2-3=1111111, held; en=1, out_ready=0.
  - Response: out_valid rises after edge 4 of stability; value=16'h0012, blank=4'b1100, err=0.
  - Then pulse out_ready for one edge -> out_valid=0. No re-commit while the pattern is held.
- Glitch rejection: after the commit above, change digit0 to 0110000 for 2 cycles, then restore -> no commit and out_valid stays 0. Holding 0110000 for ≥5 cycles instead -> commit with value=16'h0013.
- Illegal glyph: digit0=1111110 held -> err=4'b0001 and value[3:0]=0 on commit.
- Overrun and simultaneous events:
  - out_ready=0, commit pattern A, then stable pattern B -> value=B, out_valid=1, overrun=1.
  - After reset, assert out_ready on the exact commit edge of B while A is pending -> out_valid stays 1, value=B, overrun=0.
- Enable and reset mid-operation:
  - en=0 for 10 cycles while cnt=2 -> cnt holds, no commit, and accept still works.
  - reset=0 for one edge while cnt=2 -> cnt=0 and all outputs at reset values. The following stable pattern needs the full 5 edges to commit.
